// File: rtl/module_knob_panel_ctrl_pkg.sv
// Shared encodings for the Mock8080 front-panel editor.
// Field/state codes double as the panel "field" display value.
package module_knob_pkg;

  typedef enum logic [1:0] {
    FIELD_ADDR_HI = 2'd0,
    FIELD_ADDR_LO = 2'd1,
    FIELD_DATA    = 2'd2,
    FIELD_WRITE   = 2'd3
  } field_e;

  localparam logic [7:0] STEP_FINE   = 8'd1;
  localparam logic [7:0] STEP_COARSE = 8'd16;

endpackage

// File: rtl/module_knob_panel_ctrl_if.sv
// Memory write port of the front panel, also feeding the display.
// The controller is master; memory (or a bench) is slave.
interface module_knob_panel_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        wr_req;
  logic        wr_ack;
  logic        wr_err;

  modport master (
    output addr,
    output data,
    output wr_req,
    output wr_err,
    input  wr_ack
  );

  modport slave (
    input  addr,
    input  data,
    input  wr_req,
    input  wr_err,
    output wr_ack
  );
endinterface

// File: rtl/module_knob_panel_ctrl_step_gen.sv
// Turns a rotary pulse/direction event into a signed byte step.
// Coarse steps need KNOB_ACCEL_EN; otherwise the step is always fine.
module module_knob_step_gen
  import module_knob_pkg::*;
`ifdef KNOB_ACCEL_EN
#(
  parameter int ACCEL_WINDOW = 2_000_000,
  parameter int CW = $clog2(ACCEL_WINDOW + 1)
)
`endif
(
  input  logic              pulse,
  input  logic              direction,
`ifdef KNOB_ACCEL_EN
  input  logic [CW-1:0]     gap,
`endif
  output logic signed [7:0] step,
  output logic              step_valid
);

  logic [7:0] mag;

`ifdef KNOB_ACCEL_EN
  assign mag = (gap < CW'(ACCEL_WINDOW)) ? STEP_COARSE : STEP_FINE;
`else
  assign mag = STEP_FINE;
`endif

  assign step = direction ? signed'(mag) : -signed'(mag);
  assign step_valid = pulse;

endmodule

// File: rtl/module_knob_panel_ctrl.sv
// Front-panel edit controller: ADDR_HI -> ADDR_LO -> DATA -> WRITE.
// Optional KNOB_ACCEL_EN enables coarse steps on fast rotation.
module module_knob_panel_ctrl
  import module_knob_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 255,
  parameter int ACCEL_WINDOW = 2_000_000
)(
  input  logic                      qzt_clk,
  input  logic                      reset,
  input  logic                      pulse,
  input  logic                      direction,
  input  logic                      btn,
  output logic [1:0]                field,
  module_knob_panel_ctrl_if.master  wr
);

  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535 || ACCEL_WINDOW < 1) begin : g_bad_cfg
    $error("module_knob_panel_ctrl: bad ACK_TIMEOUT/ACCEL_WINDOW");
  end

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  field_e            state;
  logic [15:0]       addr_q;
  logic [7:0]        data_q;
  logic              req_q;
  logic              err_q;
  logic              btn_old;
  logic [15:0]       to_cnt;
  logic              press;
  logic signed [7:0] step;
  logic [7:0]        step_u;
  logic              step_valid;

  assign press  = btn & ~btn_old;
  assign step_u = step;

`ifdef KNOB_ACCEL_EN
  localparam int CW = $clog2(ACCEL_WINDOW + 1);
  localparam logic [CW-1:0] GAP_MAX = CW'(ACCEL_WINDOW);

  logic [CW-1:0] gap_q;
  logic          step_take;

  // Only steps that actually edit a field restart the gap measurement.
  assign step_take = step_valid & ~press & (state != FIELD_WRITE);

  always_ff @(posedge qzt_clk) begin
    if (reset)
      gap_q <= GAP_MAX;
    else if (step_take)
      gap_q <= CW'(1);
    else if (gap_q != GAP_MAX)
      gap_q <= gap_q + CW'(1);
  end

  module_knob_step_gen #(
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .CW           (CW)
  ) u_step (
    .pulse      (pulse),
    .direction  (direction),
    .gap        (gap_q),
    .step       (step),
    .step_valid (step_valid)
  );
`else
  module_knob_step_gen u_step (
    .pulse      (pulse),
    .direction  (direction),
    .step       (step),
    .step_valid (step_valid)
  );
`endif

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state   <= FIELD_ADDR_HI;
      addr_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      btn_old <= 1'b0;
      to_cnt  <= '0;
    end else begin
      btn_old <= btn;
      unique case (state)
        FIELD_ADDR_HI: begin
          if (press)
            state <= FIELD_ADDR_LO;
          else if (step_valid)
            addr_q[15:8] <= addr_q[15:8] + step_u;
        end
        FIELD_ADDR_LO: begin
          if (press)
            state <= FIELD_DATA;
          else if (step_valid)
            addr_q[7:0] <= addr_q[7:0] + step_u;
        end
        FIELD_DATA: begin
          if (press) begin
            state  <= FIELD_WRITE;
            req_q  <= 1'b1;
            to_cnt <= '0;
          end else if (step_valid) begin
            data_q <= data_q + step_u;
          end
        end
        FIELD_WRITE: begin
          // Ack wins over a timeout landing on the same edge.
          if (wr.wr_ack) begin
            state  <= FIELD_DATA;
            req_q  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= addr_q + 16'd1;
          end else if (to_cnt == TO_LAST) begin
            state <= FIELD_DATA;
            req_q <= 1'b0;
            err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign field     = state;
  assign wr.addr   = addr_q;
  assign wr.data   = data_q;
  assign wr.wr_req = req_q;
  assign wr.wr_err = err_q;

endmodule

// File: tb/tb_module_knob_panel_ctrl.sv
// Bench for module_knob_panel_ctrl: directed literals plus random
// stimulus checked every cycle against a behavioural panel model.
module tb_module_knob_panel_ctrl;

  localparam int ACK_TO = 8;
  localparam int AW     = 10;

  logic qzt_clk = 1'b0;
  logic reset = 1'b1;
  logic pulse = 1'b0;
  logic direction = 1'b0;
  logic btn = 1'b0;
  logic [1:0] field;

  module_knob_panel_ctrl_if wr_bus ();

  module_knob_panel_ctrl #(
    .ACK_TIMEOUT  (ACK_TO),
    .ACCEL_WINDOW (AW)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .pulse     (pulse),
    .direction (direction),
    .btn       (btn),
    .field     (field),
    .wr        (wr_bus.master)
  );

  always #5 qzt_clk = ~qzt_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: whole-number panel values, updated per clock.
  int m_hi, m_lo, m_data, m_field, m_wait;
  bit m_req, m_err, m_bprev;
`ifdef KNOB_ACCEL_EN
  longint m_cyc = 0;
  longint m_last = 0;
  bit m_have_last = 0;
`endif

  always @(posedge qzt_clk) begin
    bit press;
    int amt;
    bit fast;
    press = btn && !m_bprev;
    fast = 0;
`ifdef KNOB_ACCEL_EN
    m_cyc++;
    fast = m_have_last && ((m_cyc - m_last) < AW);
`endif
    if (reset) begin
      m_hi = 0; m_lo = 0; m_data = 0; m_field = 0;
      m_req = 0; m_err = 0; m_bprev = 0; m_wait = 0;
`ifdef KNOB_ACCEL_EN
      m_have_last = 0;
`endif
    end else begin
      m_bprev = btn;
      if (m_field == 3) begin
        m_wait++;
        if (wr_bus.wr_ack) begin
          m_req = 0; m_err = 0; m_field = 2;
          m_lo = m_lo + 1;
          if (m_lo == 256) begin
            m_lo = 0;
            m_hi = (m_hi + 1) % 256;
          end
        end else if (m_wait >= ACK_TO) begin
          m_req = 0; m_err = 1; m_field = 2;
        end
      end else if (press) begin
        m_field++;
        if (m_field == 3) begin
          m_req = 1;
          m_wait = 0;
        end
      end else if (pulse) begin
        amt = fast ? 16 : 1;
        if (!direction) amt = 256 - amt;
        if (m_field == 0) m_hi = (m_hi + amt) % 256;
        else if (m_field == 1) m_lo = (m_lo + amt) % 256;
        else m_data = (m_data + amt) % 256;
`ifdef KNOB_ACCEL_EN
        m_last = m_cyc;
        m_have_last = 1;
`endif
      end
    end
  end

  // Single compare process, one sample per cycle after the edge settles.
  always @(posedge qzt_clk) begin
    #1;
    chk("m_addr", 32'(wr_bus.addr), 32'(m_hi * 256 + m_lo));
    chk("m_data", 32'(wr_bus.data), 32'(m_data));
    chk("m_field", 32'(field), 32'(m_field));
    chk("m_wr_req", 32'(wr_bus.wr_req), 32'(m_req));
    chk("m_wr_err", 32'(wr_bus.wr_err), 32'(m_err));
  end

  task automatic tick(input bit p, input bit d, input bit b, input bit a);
    @(negedge qzt_clk);
    pulse = p;
    direction = d;
    btn = b;
    wr_bus.wr_ack = a;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0);
  endtask

  task automatic turn(input bit d);
    tick(1, d, 0, 0);
    idle(11);
  endtask

  task automatic press_btn();
    tick(0, 0, 1, 0);
    idle(3);
  endtask

  // Long press into WRITE; counts cycles wr_req is seen high.
  task automatic do_write(input int ack_at, input bit pulses, output int hi);
    hi = 0;
    tick(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge qzt_clk);
      if (wr_bus.wr_req === 1'b1) hi++;
      pulse = pulses && (i < 3);
      direction = 1'b1;
      btn = 1'b1;
      wr_bus.wr_ack = (i == ack_at);
    end
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge qzt_clk);
    reset = 1'b1;
    pulse = 0; btn = 0; wr_bus.wr_ack = 0;
    @(negedge qzt_clk);
    reset = 1'b0;
  endtask

  initial begin
    int hi;
    bit b;
    wr_bus.wr_ack = 1'b0;
    repeat (2) @(negedge qzt_clk);
    reset = 1'b0;
    chk("rst_addr", 32'(wr_bus.addr), 32'h0);
    chk("rst_data", 32'(wr_bus.data), 32'h0);
    chk("rst_field", 32'(field), 32'h0);
    chk("rst_req", 32'(wr_bus.wr_req), 32'h0);
    chk("rst_err", 32'(wr_bus.wr_err), 32'h0);

    repeat (3) turn(1);
    chk("hi_inc", 32'(wr_bus.addr), 32'h0300);
    press_btn();
    chk("field_lo", 32'(field), 32'h1);
    turn(0);
    chk("lo_dec", 32'(wr_bus.addr), 32'h03FF);
    press_btn();
    chk("field_data", 32'(field), 32'h2);
    repeat (91) turn(0);
    chk("data_a5", 32'(wr_bus.data), 32'hA5);

    do_write(4, 0, hi);
    chk("ack_req_len", 32'(hi), 32'd5);
    chk("ack_addr", 32'(wr_bus.addr), 32'h0400);
    chk("ack_data", 32'(wr_bus.data), 32'hA5);
    chk("ack_field", 32'(field), 32'h2);
    chk("ack_err", 32'(wr_bus.wr_err), 32'h0);

    do_write(-1, 0, hi);
    chk("to_req_len", 32'(hi), 32'd8);
    chk("to_err", 32'(wr_bus.wr_err), 32'h1);
    chk("to_addr", 32'(wr_bus.addr), 32'h0400);
    chk("to_field", 32'(field), 32'h2);

    do_write(4, 1, hi);
    chk("clr_err", 32'(wr_bus.wr_err), 32'h0);
    chk("wr_pulse_data", 32'(wr_bus.data), 32'hA5);
    chk("clr_addr", 32'(wr_bus.addr), 32'h0401);

    tick(0, 0, 1, 0);
    idle(2);
    do_reset();
    chk("midrst_req", 32'(wr_bus.wr_req), 32'h0);
    tick(0, 0, 0, 1);
    idle(2);
    chk("midrst_addr", 32'(wr_bus.addr), 32'h0);
    chk("midrst_field", 32'(field), 32'h0);

    turn(0);
    chk("hi_wrap", 32'(wr_bus.addr), 32'hFF00);
    press_btn();
    turn(0);
    chk("lo_wrap", 32'(wr_bus.addr), 32'hFFFF);
    press_btn();
    turn(0);
    chk("data_wrap", 32'(wr_bus.data), 32'hFF);
    do_write(2, 0, hi);
    chk("addr_carry", 32'(wr_bus.addr), 32'h0000);

    do_reset();
    tick(1, 1, 1, 0);
    idle(2);
    chk("btn_wins_field", 32'(field), 32'h1);
    chk("btn_wins_addr", 32'(wr_bus.addr), 32'h0);

`ifdef KNOB_ACCEL_EN
    do_reset();
    press_btn();
    press_btn();
    idle(12);
    tick(1, 1, 0, 0);
    idle(2);
    chk("accel_first", 32'(wr_bus.data), 32'h01);
    idle(2);
    tick(1, 1, 0, 0);
    idle(1);
    chk("accel_fast", 32'(wr_bus.data), 32'h11);
    idle(18);
    tick(1, 1, 0, 0);
    idle(2);
    chk("accel_slow", 32'(wr_bus.data), 32'h12);
`endif

    b = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) b = ~b;
      @(negedge qzt_clk);
      reset = ($urandom_range(0, 299) == 0);
      pulse = ($urandom_range(0, 2) == 0);
      direction = $urandom_range(0, 1) == 1;
      btn = b;
      wr_bus.wr_ack = ($urandom_range(0, 3) == 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
